// File: rtl/fifo_pkg.sv
// Shared definitions for the parameterised FIFO: the FWFT mode constants
// and the log2 helper used to size pointers and addresses.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int fifo_log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: synchronous write, asynchronous read, contents are
// never reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int BITNUMBER = 8,
  parameter int LENGTH    = 8
) (
  input  logic                            clk,
  input  logic                            wr_en,
  input  logic [fifo_log2(LENGTH)-1:0]    wr_addr,
  input  logic [BITNUMBER-1:0]            wr_data,
  input  logic [fifo_log2(LENGTH)-1:0]    rd_addr,
  output logic [BITNUMBER-1:0]            rd_data
);

  logic [BITNUMBER-1:0] mem [LENGTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_param.sv
// Single-clock FIFO with registered or first-word-fall-through read,
// programmable almost-full/almost-empty thresholds and error reporting.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int BITNUMBER = 8,
  parameter int LENGTH    = 8,
  parameter int FWFT      = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [BITNUMBER-1:0]          Fifo_Data_in,
  input  logic                          Fifo_wr,
  input  logic                          Fifo_rd,
  input  logic [fifo_log2(LENGTH):0]    afull_thr,
  input  logic [fifo_log2(LENGTH):0]    aempty_thr,
  input  logic                          err_clr,
  output logic [BITNUMBER-1:0]          Fifo_Data_out,
  output logic                          Fifo_valid,
  output logic                          Fifo_full,
  output logic                          Fifo_empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [fifo_log2(LENGTH):0]    Fifo_count,
  output logic                          Fifo_wr_error,
  output logic                          Fifo_rd_error,
  output logic                          Fifo_error
);

  localparam int AW = fifo_log2(LENGTH);
  localparam logic [AW:0] DEPTH = (AW + 1)'(LENGTH);

  // The extra pointer MSB separates a full FIFO from an empty one.
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic [BITNUMBER-1:0] rd_data;
  logic                 rd_accept;
  logic                 wr_accept;
  logic                 wr_fail;
  logic                 rd_fail;

  assign Fifo_count   = wr_ptr - rd_ptr;
  assign Fifo_empty   = (Fifo_count == '0);
  assign Fifo_full    = (Fifo_count == DEPTH);
  assign almost_full  = (Fifo_count >= afull_thr);
  assign almost_empty = (Fifo_count <= aempty_thr);

  // A read on a full FIFO frees a slot for a write in the same cycle.
  assign rd_accept = Fifo_rd && !Fifo_empty;
  assign wr_accept = Fifo_wr && (!Fifo_full || rd_accept);
  assign wr_fail   = Fifo_wr && !wr_accept;
  assign rd_fail   = Fifo_rd && !rd_accept;

  fifo_mem #(
    .BITNUMBER (BITNUMBER),
    .LENGTH    (LENGTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (Fifo_Data_in),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      Fifo_wr_error <= 1'b0;
      Fifo_rd_error <= 1'b0;
      Fifo_error    <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
      Fifo_wr_error <= wr_fail;
      Fifo_rd_error <= rd_fail;
      // A new error in the same cycle as a clear keeps the sticky flag set.
      if (wr_fail || rd_fail) Fifo_error <= 1'b1;
      else if (err_clr)       Fifo_error <= 1'b0;
    end
  end

  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      assign Fifo_Data_out = rd_data;
      assign Fifo_valid    = !Fifo_empty;
    end else begin : g_std
      logic [BITNUMBER-1:0] dout_q;
      logic                 vld_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          dout_q <= '0;
          vld_q  <= 1'b0;
        end else begin
          vld_q <= rd_accept;
          if (rd_accept) dout_q <= rd_data;
        end
      end

      assign Fifo_Data_out = dout_q;
      assign Fifo_valid    = vld_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: a registered-read instance and an FWFT
// instance, each scenario in its own task with inline comparisons.
module tb_fifo_param;

  localparam int BW = 8;
  localparam int LEN = 8;
  localparam int AW = 3;

  logic          clk;
  logic          reset;
  logic [BW-1:0] din;
  logic          wr;
  logic          rd;
  logic [AW:0]   afull_thr;
  logic [AW:0]   aempty_thr;
  logic          err_clr;
  logic [BW-1:0] dout;
  logic          valid;
  logic          full;
  logic          empty;
  logic          afull;
  logic          aempty;
  logic [AW:0]   count;
  logic          wr_err;
  logic          rd_err;
  logic          err;

  logic [BW-1:0] f_din;
  logic          f_wr;
  logic          f_rd;
  logic [BW-1:0] f_dout;
  logic          f_valid;
  logic          f_full;
  logic          f_empty;
  logic          f_afull;
  logic          f_aempty;
  logic [AW:0]   f_count;
  logic          f_wr_err;
  logic          f_rd_err;
  logic          f_err;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_param #(.BITNUMBER(BW), .LENGTH(LEN), .FWFT(0)) dut (
    .clk           (clk),
    .reset         (reset),
    .Fifo_Data_in  (din),
    .Fifo_wr       (wr),
    .Fifo_rd       (rd),
    .afull_thr     (afull_thr),
    .aempty_thr    (aempty_thr),
    .err_clr       (err_clr),
    .Fifo_Data_out (dout),
    .Fifo_valid    (valid),
    .Fifo_full     (full),
    .Fifo_empty    (empty),
    .almost_full   (afull),
    .almost_empty  (aempty),
    .Fifo_count    (count),
    .Fifo_wr_error (wr_err),
    .Fifo_rd_error (rd_err),
    .Fifo_error    (err)
  );

  fifo_param #(.BITNUMBER(BW), .LENGTH(LEN), .FWFT(1)) dut_fwft (
    .clk           (clk),
    .reset         (reset),
    .Fifo_Data_in  (f_din),
    .Fifo_wr       (f_wr),
    .Fifo_rd       (f_rd),
    .afull_thr     (afull_thr),
    .aempty_thr    (aempty_thr),
    .err_clr       (err_clr),
    .Fifo_Data_out (f_dout),
    .Fifo_valid    (f_valid),
    .Fifo_full     (f_full),
    .Fifo_empty    (f_empty),
    .almost_full   (f_afull),
    .almost_empty  (f_aempty),
    .Fifo_count    (f_count),
    .Fifo_wr_error (f_wr_err),
    .Fifo_rd_error (f_rd_err),
    .Fifo_error    (f_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [BW-1:0] v);
    wr = 1'b1; din = v;
    step();
    wr = 1'b0;
  endtask

  task automatic pop();
    rd = 1'b1;
    step();
    rd = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", full); end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if ({valid, wr_err, rd_err, err} !== 4'b0) begin n_bad++; $display("FAIL reset_ctrl: got %b want 0000", {valid, wr_err, rd_err, err}); end
    n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL reset_dout: got %h want 00", dout); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      push(BW'(i));
      n_cmp++; if (count !== 4'(i)) begin n_bad++; $display("FAIL fill_count: got %0d want %0d", count, i); end
    end
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL fill_full: got %b want 1", full); end
    rd = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      n_cmp++; if (valid !== 1'b1 || dout !== BW'(i)) begin n_bad++; $display("FAIL drain_data: got %b/%h want 1/%h", valid, dout, BW'(i)); end
    end
    rd = 1'b0;
    step();
    n_cmp++; if (valid !== 1'b0 || empty !== 1'b1) begin n_bad++; $display("FAIL drain_end: got valid %b empty %b want 0 1", valid, empty); end
  endtask

  task automatic test_full_wr_error();
    for (int i = 1; i <= 8; i++) push(BW'(i));
    push(8'h99);
    n_cmp++; if (wr_err !== 1'b1 || err !== 1'b1) begin n_bad++; $display("FAIL full_wr_err: got %b%b want 11", wr_err, err); end
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL full_wr_count: got %0d want 8", count); end
    step();
    n_cmp++; if (wr_err !== 1'b0 || err !== 1'b1) begin n_bad++; $display("FAIL wr_err_pulse: got %b%b want 01", wr_err, err); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clr: got %b want 0", err); end
  endtask

  task automatic test_full_simul();
    wr = 1'b1; rd = 1'b1; din = 8'hAA;
    step();
    wr = 1'b0; rd = 1'b0;
    n_cmp++; if ({wr_err, rd_err} !== 2'b00 || count !== 4'd8) begin n_bad++; $display("FAIL simul_full: got err %b%b count %0d want 00 8", wr_err, rd_err, count); end
    n_cmp++; if (dout !== 8'h01) begin n_bad++; $display("FAIL simul_dout: got %h want 01", dout); end
    for (int i = 2; i <= 8; i++) begin
      pop();
      n_cmp++; if (dout !== BW'(i)) begin n_bad++; $display("FAIL simul_order: got %h want %h", dout, BW'(i)); end
    end
    pop();
    n_cmp++; if (dout !== 8'hAA || empty !== 1'b1) begin n_bad++; $display("FAIL simul_last: got %h empty %b want AA 1", dout, empty); end
  endtask

  task automatic test_empty_read();
    pop();
    n_cmp++; if (rd_err !== 1'b1 || err !== 1'b1) begin n_bad++; $display("FAIL empty_rd_err: got %b%b want 11", rd_err, err); end
    n_cmp++; if (dout !== 8'hAA || valid !== 1'b0) begin n_bad++; $display("FAIL empty_rd_dout: got %h valid %b want AA 0", dout, valid); end
    // write into an empty FIFO with a concurrent read: read rejected
    wr = 1'b1; rd = 1'b1; din = 8'h33;
    step();
    wr = 1'b0; rd = 1'b0;
    n_cmp++; if (rd_err !== 1'b1 || wr_err !== 1'b0 || count !== 4'd1) begin n_bad++; $display("FAIL wr_rd_empty: got rderr %b wrerr %b count %0d want 1 0 1", rd_err, wr_err, count); end
    pop();
    n_cmp++; if (valid !== 1'b1 || dout !== 8'h33) begin n_bad++; $display("FAIL wr_rd_empty_data: got %b/%h want 1/33", valid, dout); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  task automatic test_fwft();
    n_cmp++; if (f_valid !== 1'b0 || f_empty !== 1'b1) begin n_bad++; $display("FAIL fwft_idle: got valid %b empty %b want 0 1", f_valid, f_empty); end
    f_wr = 1'b1; f_din = 8'h5C;
    step();
    f_wr = 1'b0;
    n_cmp++; if (f_valid !== 1'b1 || f_dout !== 8'h5C) begin n_bad++; $display("FAIL fwft_show: got %b/%h want 1/5C", f_valid, f_dout); end
    f_rd = 1'b1;
    step();
    f_rd = 1'b0;
    n_cmp++; if (f_valid !== 1'b0 || f_empty !== 1'b1 || f_rd_err !== 1'b0) begin n_bad++; $display("FAIL fwft_pop: got valid %b empty %b rderr %b want 0 1 0", f_valid, f_empty, f_rd_err); end
  endtask

  task automatic test_thresholds();
    afull_thr = 4'd6; aempty_thr = 4'd1;
    #1;
    for (int k = 0; k <= 8; k++) begin
      n_cmp++; if (aempty !== (k <= 1) || afull !== (k >= 6)) begin n_bad++; $display("FAIL thr_count%0d: got ae %b af %b want %b %b", k, aempty, afull, (k <= 1), (k >= 6)); end
      if (k < 8) push(BW'(k));
    end
    for (int k = 0; k < 8; k++) pop();
    n_cmp++; if (empty !== 1'b1 || aempty !== 1'b1 || afull !== 1'b0) begin n_bad++; $display("FAIL thr_drained: got e %b ae %b af %b want 1 1 0", empty, aempty, afull); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) push(BW'(8'h10 + i));
    for (int i = 0; i < 20; i++) begin
      wr = 1'b1; rd = 1'b1; din = BW'(8'h14 + i);
      step();
      n_cmp++; if (dout !== BW'(8'h10 + i) || count !== 4'd4) begin n_bad++; $display("FAIL wrap%0d: got %h count %0d want %h 4", i, dout, count, BW'(8'h10 + i)); end
    end
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic test_async_reset();
    push(8'hEE);
    n_cmp++; if (count !== 4'd5) begin n_bad++; $display("FAIL pre_reset_count: got %0d want 5", count); end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin n_bad++; $display("FAIL async_reset: got count %0d e %b f %b want 0 1 0", count, empty, full); end
    n_cmp++; if (dout !== 8'h00 || valid !== 1'b0) begin n_bad++; $display("FAIL async_reset_dout: got %h/%b want 00/0", dout, valid); end
    #1 reset = 1'b0;
    pop();
    n_cmp++; if (rd_err !== 1'b1 || err !== 1'b1 || valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_rd: got rderr %b err %b valid %b want 1 1 0", rd_err, err, valid); end
  endtask

  initial begin
    reset = 1'b1; din = '0; wr = 1'b0; rd = 1'b0; err_clr = 1'b0;
    afull_thr = 4'd8; aempty_thr = 4'd0;
    f_din = '0; f_wr = 1'b0; f_rd = 1'b0;
    test_reset();
    test_fill_drain();
    test_full_wr_error();
    test_full_simul();
    test_empty_read();
    test_fwft();
    test_thresholds();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 Parameter BITNUMBER, default 8: data word width in bits, minimum 1.
REQ-002 Parameter LENGTH, default 8: depth in words, a power of 2, minimum 2; AW = log2(LENGTH).
REQ-003 Parameter FWFT, default 0: 0 = standard registered read; 1 = first-word-fall-through.
REQ-004 Ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- Fifo_Data_in  in  BITNUMBER  write data.
- Fifo_wr  in  1  write request.
- Fifo_rd  in  1  read request.
- afull_thr  in  AW+1  almost-full threshold.
- aempty_thr  in  AW+1  almost-empty threshold.
- err_clr  in  1  clears the sticky error.
- Fifo_Data_out  out  BITNUMBER  read data.
- Fifo_valid  out  1  Fifo_Data_out holds a valid word.
- Fifo_full, Fifo_empty  out  1 each  occupancy flags.
- almost_full, almost_empty  out  1 each  threshold flags.
- Fifo_count  out  AW+1  occupancy, 0..LENGTH.
- Fifo_wr_error, Fifo_rd_error  out  1 each  one-cycle error pulses.
- Fifo_error  out  1  sticky error.

Function
REQ-005 Write and read pointers SHALL be AW+1 bits wide; the extra MSB distinguishes full from empty.
REQ-006 Fifo_count SHALL equal wr_ptr - rd_ptr, computed modulo 2^(AW+1).
REQ-007 Fifo_empty SHALL be 1 when count==0; Fifo_full SHALL be 1 when count==LENGTH. Both are decoded combinationally from registered pointers.
REQ-008 rd_accept = Fifo_rd && !Fifo_empty.
REQ-009 wr_accept = Fifo_wr && (!Fifo_full || rd_accept); a simultaneous read frees the slot within the same cycle.
REQ-010 On wr_accept: memory[wr_ptr[AW-1:0]] <= Fifo_Data_in; wr_ptr increments.
REQ-011 On rd_accept: rd_ptr increments. Pointers wrap naturally at 2^(AW+1).
REQ-012 A simultaneous accepted read and write SHALL leave Fifo_count unchanged.
REQ-013 A write to an empty FIFO with Fifo_rd asserted SHALL NOT be read in the same cycle; that read is an error.
REQ-014 FWFT=0: on rd_accept, Fifo_Data_out SHALL register the head word on the next edge and Fifo_valid SHALL pulse high for exactly that cycle. Otherwise Fifo_Data_out holds its value.
REQ-015 FWFT=1: Fifo_Data_out SHALL equal memory[rd_ptr] combinationally and Fifo_valid = !Fifo_empty. A word written in cycle N is visible in cycle N+1.
REQ-016 almost_full = (count >= afull_thr); almost_empty = (count <= aempty_thr). Comparisons are unsigned, full width, and evaluated combinationally.
REQ-017 Fifo_wr_error SHALL pulse 1 for the cycle after Fifo_wr && !wr_accept. Fifo_rd_error SHALL pulse 1 for the cycle after Fifo_rd && !rd_accept.
REQ-018 Fifo_error SHALL set on the edge where either error pulse is generated, and hold until err_clr.
REQ-019 If err_clr and a new error occur in the same cycle, set wins.
REQ-020 Rejected operations SHALL NOT modify pointers, memory, or Fifo_Data_out.

Reset
REQ-021 Asserting reset SHALL immediately clear: wr_ptr, rd_ptr, Fifo_Data_out, Fifo_valid (FWFT=0), both error pulses, and Fifo_error. As a result Fifo_empty=1, Fifo_full=0, Fifo_count=0.
REQ-022 Memory contents SHALL NOT be reset. Reset asserted mid-operation discards all stored words.
REQ-023 On the first edge after reset deassertion, operation SHALL be normal.

Structure
REQ-024 A shared package fifo_pkg SHALL hold the log2 helper function and the FWFT mode constants (FIFO_STD=0, FIFO_FWFT=1).
REQ-025 Storage SHALL be a sub-module fifo_mem (parameters BITNUMBER, LENGTH): synchronous write, asynchronous read, no reset.

Verification
REQ-026 LENGTH=8, FWFT=0: write 0x01..0x08, then read 8 times -> Fifo_full=1 after the 8th write; data returns 0x01..0x08, each one cycle after its read; Fifo_empty=1 at the end.
REQ-027 Full FIFO: Fifo_wr without Fifo_rd -> Fifo_wr_error pulses once, Fifo_error sticks, count stays 8. Then err_clr -> Fifo_error=0.
REQ-028 Full FIFO: Fifo_wr and Fifo_rd together with data 0xAA -> no error, count stays 8; 0xAA is read out last.
REQ-029 Empty FIFO: Fifo_rd alone -> Fifo_rd_error pulses, Fifo_Data_out unchanged. Then write 0x5C with FWFT=1 -> next cycle Fifo_valid=1, Fifo_Data_out=0x5C.
REQ-030 Thresholds afull_thr=6, aempty_thr=1: fill 0..8 words -> almost_empty=1 at counts 0-1; almost_full=1 at counts 6-8. Run 20 wrap-around cycles with the data order preserved.
REQ-031 Assert reset asynchronously with 5 words stored -> flags clear before the next clk edge, count=0; a read afterwards errors.
